// File: rtl/word_byte_tx.sv
// word_byte_tx: transmit side of the 8-bit parallel host link.
// Takes a word from the core and sends it byte by byte (byte 0 first) over
// tx_data with a 4-phase strobe/ack handshake. The asynchronous tx_ack is
// synchronized before use, and each handshake phase is guarded by a timeout
// that raises a sticky err flag and drains the link.
`timescale 1ns/1ps

module word_byte_tx #(
  parameter int unsigned NBYTES         = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*NBYTES-1:0]   word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_strobe,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int unsigned WORD_W    = 8 * NBYTES;
  localparam int unsigned CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned LAST_BYTE = NBYTES - 1;
  // Timeout counter runs 0..TIMEOUT_CYCLES-1; hitting the top value aborts.
  localparam int unsigned TCNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WORD_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [TCNT_W-1:0]      r_tcnt;
  logic [7:0]             r_data;
  logic                   r_strobe;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_err;

  logic                   w_ack_s;
  logic                   w_last;
  logic                   w_to_hit;
  logic [WORD_W-1:0]      w_shift_nxt;

  // Synchronized ack, last-byte and timeout decodes, next shifted word.
  assign w_ack_s     = r_sync[SYNC_STAGES-1];
  assign w_last      = (r_cnt == CNT_W'(LAST_BYTE));
  assign w_to_hit    = TO_EN && (r_tcnt == TCNT_W'(TO_LAST));
  assign w_shift_nxt = r_shift >> 8;

  // Registered outputs driven straight from flops.
  assign word_ready = r_ready;
  assign tx_data    = r_data;
  assign tx_strobe  = r_strobe;
  assign busy       = r_busy;
  assign err        = r_err;

  // Multi-flop synchronizer for the asynchronous host acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tx_ack};
    end
  end

  // Handshake state machine with datapath, timeout and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_data   <= 8'h00;
      r_strobe <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // Clear first so a timeout later in this block takes priority.
      if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (word_valid && r_ready) begin
            r_shift <= word_in;
            r_data  <= word_in[7:0];
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end

        // One cycle of data setup before the strobe rises.
        S_SETUP: begin
          r_strobe <= 1'b1;
          r_tcnt   <= '0;
          r_state  <= S_WAIT_HI;
        end

        // Host must raise ack; an ack already high counts immediately.
        S_WAIT_HI: begin
          if (w_ack_s) begin
            r_strobe <= 1'b0;
            r_tcnt   <= '0;
            r_state  <= S_WAIT_LO;
          end else if (w_to_hit) begin
            r_err    <= 1'b1;
            r_strobe <= 1'b0;
            r_tcnt   <= '0;
            r_state  <= S_DRAIN;
          end else if (TO_EN) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end

        // Host must release ack before the next byte is presented.
        S_WAIT_LO: begin
          if (!w_ack_s) begin
            r_tcnt <= '0;
            if (w_last) begin
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_shift <= w_shift_nxt;
              r_data  <= w_shift_nxt[7:0];
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= S_SETUP;
            end
          end else if (w_to_hit) begin
            r_err    <= 1'b1;
            r_strobe <= 1'b0;
            r_tcnt   <= '0;
            r_state  <= S_DRAIN;
          end else if (TO_EN) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end

        // After an abort, wait without limit for the host to release ack.
        S_DRAIN: begin
          if (!w_ack_s) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_strobe <= 1'b0;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_byte_tx.sv
// Directed bench for word_byte_tx with a behavioural host on the link.
`timescale 1ns/1ps

module tb_word_byte_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic        tx_ack = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Host behaviour: 0 = ack 2 cycles after strobe, 1 = never ack, 2 = ack stuck high
  int         host_mode = 0;
  int         host_cnt  = 0;
  int         stab_err  = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] q[$];

  word_byte_tx #(
    .NBYTES(4),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .tx_data(tx_data),
    .tx_strobe(tx_strobe),
    .tx_ack(tx_ack),
    .busy(busy),
    .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Host model and byte monitor, both on the falling edge.
  always @(negedge clk) begin
    if (tx_strobe && !prev_strobe) begin
      q.push_back(tx_data);
    end else if (tx_strobe && q.size() > 0 && tx_data != q[$]) begin
      stab_err = stab_err + 1;
    end
    prev_strobe = tx_strobe;
    case (host_mode)
      0: begin
        if (tx_strobe && !tx_ack) begin
          host_cnt = host_cnt + 1;
          if (host_cnt >= 2) begin
            tx_ack   = 1'b1;
            host_cnt = 0;
          end
        end else if (!tx_strobe) begin
          tx_ack   = 1'b0;
          host_cnt = 0;
        end
      end
      1: tx_ack = 1'b0;
      default: tx_ack = 1'b1;
    endcase
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mode(input int m);
    @(posedge clk);
    #2;
    host_mode = m;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!(word_ready && !busy) && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (i >= 300) chk_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Called at a falling edge with the block idle; accept happens at the next rising edge.
  task automatic send_word(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] w, input int base);
    for (int i = 0; i < 4; i++) begin
      chk_eq(tag, 32'(q[base + i]), 32'(w[8*i +: 8]));
    end
  endtask

  // Counts falling-edge samples with strobe high; optionally raises err_clr before sample clr_at+1.
  task automatic strobe_window(input int clr_at, output int n);
    int i;
    n = 0;
    i = 0;
    while (!tx_strobe && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (i >= 40) chk_eq("strobe_rise_timeout", 32'(tx_strobe), 32'd1);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      if (n == clr_at) err_clr = 1'b1;
      @(negedge clk);
      if (!tx_strobe) break;
      n++;
    end
  endtask

  initial begin
    int n;
    int acc;
    int ready_cnt;
    int bad_cnt;
    logic last_ready;

    // Reset values and single word
    #3 rst_n = 1'b0;
    #1;
    chk_eq("rst_data", 32'(tx_data), 32'h00);
    chk_eq("rst_strobe", 32'(tx_strobe), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("ready_after_rst", 32'(word_ready), 32'd1);
    q.delete();
    send_word(32'hDEADBEEF);
    chk_eq("busy_after_accept", 32'(busy), 32'd1);
    chk_eq("ready_after_accept", 32'(word_ready), 32'd0);
    wait_idle();
    chk_eq("w1_count", 32'(q.size()), 32'd4);
    check_bytes("w1_byte", 32'hDEADBEEF, 0);
    chk_eq("w1_ready", 32'(word_ready), 32'd1);
    chk_eq("w1_err", 32'(err), 32'd0);
    chk_eq("w1_last_data_held", 32'(tx_data), 32'hDE);

    // Back-to-back words with word_valid held high
    q.delete();
    word_in    = 32'h03020100;
    word_valid = 1'b1;
    last_ready = word_ready;
    acc = 0;
    ready_cnt = 0;
    bad_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (last_ready && word_valid) begin
        acc++;
        if (acc == 1) word_in = 32'h07060504;
        if (acc == 2) word_valid = 1'b0;
      end
      if (acc == 1 && word_ready) ready_cnt++;
      if (acc == 1 && (word_ready == busy)) bad_cnt++;
      last_ready = word_ready;
      if (acc == 2 && !busy) break;
    end
    word_valid = 1'b0;
    chk_eq("b2b_accepts", 32'(acc), 32'd2);
    chk_eq("b2b_ready_gap", 32'(ready_cnt), 32'd1);
    chk_eq("b2b_busy_gap", 32'(bad_cnt), 32'd0);
    chk_eq("b2b_count", 32'(q.size()), 32'd8);
    check_bytes("b2b_w0", 32'h03020100, 0);
    check_bytes("b2b_w1", 32'h07060504, 4);
    chk_eq("stable_data", 32'(stab_err), 32'd0);

    // Timeout with a silent host, then a normal word
    set_mode(1);
    wait_idle();
    q.delete();
    send_word(32'h44332211);
    strobe_window(0, n);
    chk_eq("to_strobe_len", 32'(n), 32'd8);
    chk_eq("to_err", 32'(err), 32'd1);
    chk_eq("to_drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk_eq("to_drain_exit", 32'(busy), 32'd0);
    chk_eq("to_ready", 32'(word_ready), 32'd1);
    chk_eq("to_one_byte", 32'(q.size()), 32'd1);
    set_mode(0);
    wait_idle();
    q.delete();
    send_word(32'h0A0B0C0D);
    wait_idle();
    chk_eq("to_next_count", 32'(q.size()), 32'd4);
    check_bytes("to_next", 32'h0A0B0C0D, 0);
    chk_eq("to_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_eq("err_clr", 32'(err), 32'd0);

    // err_clr asserted on the timeout edge: set wins, clear next cycle
    set_mode(1);
    wait_idle();
    send_word(32'h11111111);
    strobe_window(8, n);
    chk_eq("clr_strobe_len", 32'(n), 32'd8);
    chk_eq("clr_vs_set", 32'(err), 32'd1);
    @(negedge clk);
    err_clr = 1'b0;
    chk_eq("clr_after", 32'(err), 32'd0);

    // Stuck-high ack: one byte, timeout in WAIT_LO, stays in DRAIN until release
    set_mode(2);
    repeat (4) @(negedge clk);
    wait_idle();
    q.delete();
    send_word(32'hCAFEF00D);
    for (int k = 0; k < 40; k++) begin
      if (err) break;
      @(negedge clk);
    end
    chk_eq("stuck_err", 32'(err), 32'd1);
    chk_eq("stuck_one_byte", 32'(q.size()), 32'd1);
    chk_eq("stuck_byte0", 32'(q[0]), 32'h0D);
    repeat (5) @(negedge clk);
    chk_eq("stuck_in_drain", 32'(busy), 32'd1);
    chk_eq("stuck_not_ready", 32'(word_ready), 32'd0);
    set_mode(0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    chk_eq("stuck_release_lat", 32'(n), 32'd3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Reset mid-word during byte 2 with strobe high
    wait_idle();
    q.delete();
    send_word(32'h55667788);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 3 && tx_strobe) break;
    end
    chk_eq("mid_strobe_hi", 32'(tx_strobe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_strobe", 32'(tx_strobe), 32'd0);
    chk_eq("mid_rst_data", 32'(tx_data), 32'h00);
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_eq("mid_no_residual", 32'(q.size()), 32'd3);
    chk_eq("mid_byte2", 32'(q[2]), 32'h66);
    chk_eq("mid_ready", 32'(word_ready), 32'd1);
    chk_eq("mid_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_byte_tx.md
Name: word_byte_tx

Overview:
- Transmit side of the chip's 8-bit parallel host link; complements the byte-input path on ui_in/uio_in.
- Accepts 32-bit words from the RV32I core (store data, debug/trace words) and sends them off-chip as NBYTES bytes on uo_out.
- Each byte uses a 4-phase strobe/ack handshake: strobe on a uio output bit, ack on a uio input bit.
- Includes an ack synchronizer, a per-phase timeout and a sticky error flag.

Parameters:
- NBYTES, 4: bytes per word. Byte 0 (bits 7:0) is sent first, little-endian.
- SYNC_STAGES, 2: flip-flop stages on tx_ack. Legal values are 2 or more.
- TIMEOUT_CYCLES, 1023: cycles to wait for an ack edge before aborting. 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- word_in  input  8*NBYTES  word to transmit
- word_valid  input  1  word_in is valid
- word_ready  output  1  block can accept a word
- tx_data  output  8  byte bus, drives uo_out
- tx_strobe  output  1  byte-valid strobe, drives uio_out[0] (uio_oe[0]=1)
- tx_ack  input  1  host acknowledge from uio_in[0], asynchronous
- busy  output  1  a word is in flight
- err  output  1  sticky timeout flag
- err_clr  input  1  synchronous clear of err

Behaviour:
- Reset: clk and rst_n only. rst_n low asynchronously clears:
  - state to IDLE and synchronizer flops to 0;
  - tx_data=0x00, tx_strobe=0, busy=0, err=0;
  - byte counter and timeout counter.
  - word_ready=1 from the first clock after reset release.
- Reset mid-word aborts immediately. No partial resume.
- All outputs are registered or decoded from registered state only.
- ack_s is tx_ack after SYNC_STAGES flops. All decisions use ack_s only.
- States: IDLE, SETUP, WAIT_HI, WAIT_LO, DRAIN.
- IDLE:
  - word_ready=1, busy=0.
  - On word_valid&&word_ready, at that edge: capture word_in into a shift register, tx_data<=byte0, counter<=0, go to SETUP.
  - word_in may change after the accept edge.
- SETUP, one cycle: data setup. tx_strobe<=1, go to WAIT_HI, clear timeout counter.
- WAIT_HI:
  - When ack_s=1: tx_strobe<=0, go to WAIT_LO, clear timeout counter.
- WAIT_LO, when ack_s=0:
  - Counter != NBYTES-1: shift, tx_data<=next byte, counter++, go to SETUP.
  - Counter == NBYTES-1: go to IDLE.
- tx_data holds the last byte sent until the next accept.
- tx_data only changes while tx_strobe=0 and ack_s=0.
- Minimum time per byte: 3 cycles plus 2×SYNC_STAGES of synchronizer latency.
- word_ready=1 in IDLE only. busy = not IDLE. No accept in any other state.
- Timeout (TIMEOUT_CYCLES>0):
  - Timeout counter increments each cycle in WAIT_HI and WAIT_LO.
  - Reaching TIMEOUT_CYCLES: err<=1, tx_strobe<=0, remaining bytes discarded, go to DRAIN.
- DRAIN: no timeout. Wait for ack_s=0, then go to IDLE. The host must release ack to recover.
- err:
  - Set only by a timeout. Cleared by err_clr=1 at a clock edge.
  - Set and clear in the same cycle: set wins.
  - err does not block new words.
- ack_s already 1 on entry to WAIT_HI, e.g. a stuck host: this counts as an ack. The state machine proceeds to WAIT_LO and the timeout covers the stuck-high case.
- word_valid held high across words: words transmit back-to-back with one IDLE cycle between them.
- tx_ack glitch shorter than one clock: may or may not be seen. It cannot produce a metastable state decision.

Test Plan:
- Reset and single word:
  - Stimulus: hold rst_n=0, release; accept 0xDEADBEEF; host acks each strobe after 2 cycles.
  - Response: tx_data=0xEF,0xBE,0xAD,0xDE in order, each stable while strobe=1.
  - Response: 4 strobe pulses, word_ready returns 1, err=0.
- Back-to-back:
  - Stimulus: word_valid held high with 0x03020100 then 0x07060504.
  - Response: bytes 00..07 in order; word_ready=1 for exactly one cycle between the words; busy=1 otherwise.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, host never acks.
  - Response: strobe drops 8 cycles after WAIT_HI entry; err=1; DRAIN exits after ack_s=0; next word sends normally.
- Stuck-high ack:
  - Stimulus: tx_ack=1 permanently.
  - Response: first byte passes WAIT_HI, times out in WAIT_LO, err=1, block stays in DRAIN.
  - Response: releasing tx_ack returns the block to IDLE after SYNC_STAGES+1 cycles.
- err_clr vs set:
  - Stimulus: assert err_clr in the same cycle a timeout fires.
  - Response: err=1. err_clr the next cycle gives err=0.
- Reset mid-word:
  - Stimulus: assert rst_n=0 during byte 2, with strobe=1.
  - Response: tx_strobe=0 and tx_data=0x00 immediately (asynchronous); after release word_ready=1 and no residual bytes are sent.
